// File: rtl/decode_r32i.sv
// decode_r32i: registered RV32I integer decode stage.
// Turns a 32-bit instruction word into ALU controls, register addresses and
// an immediate. An output register plus a skid register keep one instruction
// per cycle flowing while letting execute stall without losing an entry.
module decode_r32i #(
   parameter int dataW = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [dataW-1:0] pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [dataW-1:0] out_pc,
   output logic [3:0]       alucode,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [4:0]       rd,
   output logic [31:0]      imm,
   output logic             a_sel_pc,
   output logic             b_sel_imm,
   output logic             b_negate,
   output logic             reg_write,
   output logic             illegal
);

   // ALU operation codes shared with the execute stage
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SLT  = 4'd1;
   localparam logic [3:0] ALU_SLTU = 4'd2;
   localparam logic [3:0] ALU_AND  = 4'd3;
   localparam logic [3:0] ALU_OR   = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SSL  = 4'd6;
   localparam logic [3:0] ALU_SSR  = 4'd7;
   localparam logic [3:0] ALU_SRA  = 4'd8;
   localparam logic [3:0] ALU_CPY  = 4'd9;

   // Major opcodes handled by this stage (all end in 2'b11, so compressed
   // encodings fall through to the illegal default automatically)
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [dataW-1:0] pc;
      logic [3:0]       alucode;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [4:0]       rd;
      logic [31:0]      imm;
      logic             a_sel_pc;
      logic             b_sel_imm;
      logic             b_negate;
      logic             reg_write;
      logic             illegal;
   } entry_t;

   // Full combinational decode of one instruction word into an entry.
   // Illegal words still produce an entry, but with every control neutralised
   // so that a consumer ignoring the illegal flag cannot write a register.
   function automatic entry_t decode_instr(input logic [31:0] w,
                                           input logic [dataW-1:0] p);
      entry_t     d;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       bad;
      f3    = w[14:12];
      f7    = w[31:25];
      bad   = 1'b0;
      d     = '0;
      d.pc  = p;
      d.rs1 = w[19:15];
      d.rs2 = w[24:20];
      d.rd  = w[11:7];
      case (w[6:0])
         OPC_OP: begin
            if (f7 == F7_BASE) begin
               case (f3)
                  3'b000:  d.alucode = ALU_ADD;
                  3'b001:  d.alucode = ALU_SSL;
                  3'b010:  d.alucode = ALU_SLT;
                  3'b011:  d.alucode = ALU_SLTU;
                  3'b100:  d.alucode = ALU_XOR;
                  3'b101:  d.alucode = ALU_SSR;
                  3'b110:  d.alucode = ALU_OR;
                  default: d.alucode = ALU_AND;
               endcase
            end else if (f7 == F7_ALT && f3 == 3'b000) begin
               // SUB: the operand mux negates B, the ALU just adds
               d.alucode  = ALU_ADD;
               d.b_negate = 1'b1;
            end else if (f7 == F7_ALT && f3 == 3'b101) begin
               d.alucode = ALU_SRA;
            end else begin
               bad = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            d.b_sel_imm = 1'b1;
            d.rs2       = 5'd0;
            d.imm       = {{20{w[31]}}, w[31:20]};
            case (f3)
               3'b000: d.alucode = ALU_ADD;
               3'b010: d.alucode = ALU_SLT;
               3'b011: d.alucode = ALU_SLTU;
               3'b100: d.alucode = ALU_XOR;
               3'b110: d.alucode = ALU_OR;
               3'b111: d.alucode = ALU_AND;
               3'b001: begin
                  // shift amount lives in the rs2 field; upper bits are f7
                  d.imm = {27'd0, w[24:20]};
                  if (f7 == F7_BASE) d.alucode = ALU_SSL;
                  else               bad = 1'b1;
               end
               default: begin
                  d.imm = {27'd0, w[24:20]};
                  if (f7 == F7_BASE)     d.alucode = ALU_SSR;
                  else if (f7 == F7_ALT) d.alucode = ALU_SRA;
                  else                   bad = 1'b1;
               end
            endcase
         end
         OPC_LUI: begin
            d.alucode   = ALU_CPY;
            d.imm       = {w[31:12], 12'd0};
            d.b_sel_imm = 1'b1;
            d.rs1       = 5'd0;
            d.rs2       = 5'd0;
         end
         OPC_AUIPC: begin
            d.alucode   = ALU_ADD;
            d.imm       = {w[31:12], 12'd0};
            d.a_sel_pc  = 1'b1;
            d.b_sel_imm = 1'b1;
            d.rs1       = 5'd0;
            d.rs2       = 5'd0;
         end
         default: bad = 1'b1;
      endcase
      if (bad) begin
         d.alucode   = ALU_ADD;
         d.imm       = '0;
         d.a_sel_pc  = 1'b0;
         d.b_sel_imm = 1'b0;
         d.b_negate  = 1'b0;
      end
      d.illegal   = bad;
      d.reg_write = !bad && (d.rd != 5'd0);
      return d;
   endfunction

   entry_t decoded;
   entry_t out_ent;
   entry_t skid_ent;
   logic   skid_full;
   logic   out_free;
   logic   accept;
   logic   load_from_skid;
   logic   load_new_out;
   logic   load_skid;

   assign decoded = decode_instr(instr, pc);

   // Steering: where (if anywhere) an entry lands on the coming edge
   always_comb begin
      out_free       = !out_valid || out_ready;
      accept         = in_valid && in_ready;
      load_from_skid = !flush && out_free && skid_full;
      load_new_out   = !flush && out_free && !skid_full && accept;
      load_skid      = !flush && !out_free && accept;
   end

   // Occupancy and handshake flags; in_ready simply mirrors "skid empty"
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         skid_full <= 1'b0;
         in_ready  <= 1'b1;
      end else if (flush) begin
         out_valid <= 1'b0;
         skid_full <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         if (out_free) out_valid <= skid_full || accept;
         if (load_from_skid) begin
            skid_full <= 1'b0;
            in_ready  <= 1'b1;
         end else if (load_skid) begin
            skid_full <= 1'b1;
            in_ready  <= 1'b0;
         end
      end
   end

   // Entry storage; cleared on reset so all data outputs read zero (ADD)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_ent  <= '0;
         skid_ent <= '0;
      end else begin
         if (load_from_skid)    out_ent <= skid_ent;
         else if (load_new_out) out_ent <= decoded;
         if (load_skid)         skid_ent <= decoded;
      end
   end

   assign out_pc    = out_ent.pc;
   assign alucode   = out_ent.alucode;
   assign rs1       = out_ent.rs1;
   assign rs2       = out_ent.rs2;
   assign rd        = out_ent.rd;
   assign imm       = out_ent.imm;
   assign a_sel_pc  = out_ent.a_sel_pc;
   assign b_sel_imm = out_ent.b_sel_imm;
   assign b_negate  = out_ent.b_negate;
   assign reg_write = out_ent.reg_write;
   assign illegal   = out_ent.illegal;

endmodule

// File: doc/decode_r32i.md
# decode_r32i

Registered RV32I integer-instruction decode stage that sits between instruction fetch and the execute stage. It turns a 32-bit instruction word into the 4-bit alucode, register addresses, immediate and operand-select controls consumed by the ALU and its operand muxes. Valid/ready handshakes are used on both sides, with a two-entry skid buffer so that full throughput is kept under downstream back-pressure.

## Interface

Parameters:
- dataW, 32, datapath and PC width

Ports (handshake-facing input side: in_*; execute-facing output side: out_*):
- clk  input  1  clock; all registers update on the rising edge
- rst  input  1  reset, asynchronous, active-high
- flush  input  1  synchronous discard of all held entries
- in_valid  input  1  instruction word offered
- in_ready  output  1  stage can accept an instruction
- instr  input  32  instruction word
- pc  input  dataW  address of instr
- out_valid  output  1  decoded entry presented
- out_ready  input  1  execute accepts the entry
- out_pc  output  dataW  pc of the entry
- alucode  output  4  ADD=0, SLT=1, SLTU=2, AND=3, OR=4, XOR=5, SSL=6, SSR=7, SRA=8, CPY=9 (the shared alucode header values)
- rs1, rs2, rd  output  5 each  register addresses
- imm  output  32  decoded immediate
- a_sel_pc  output  1  ALU A operand = out_pc instead of rs1 data
- b_sel_imm  output  1  ALU B operand = imm instead of rs2 data
- b_negate  output  1  operand mux supplies -B (SUB)
- reg_write  output  1  write the result to rd
- illegal  output  1  instruction not supported

## Operation

- A transfer happens on an edge where valid && ready on the respective side.
- Two entries: an output register and a skid register.
  - Accept while the output is empty or being drained: decode into the output register.
  - Accept while the output is stalled: decode into the skid register. in_ready deasserts on the next cycle.
  - When the output drains and the skid is full, the skid entry moves into the output register and in_ready reasserts.
- Decode fields: opcode = instr[6:0], f3 = instr[14:12], f7 = instr[31:25].
  - rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7], except where stated below.
- OP (0110011): b_sel_imm = 0.
  - With f7 = 0000000, f3 000..111 maps to ADD, SSL, SLT, SLTU, XOR, SSR, OR, AND.
  - With f7 = 0100000: f3 000 gives ADD with b_negate = 1; f3 101 gives SRA.
  - Any other f7/f3 combination is illegal.
- OP-IMM (0010011): b_sel_imm = 1. rs2 is 0.
  - f3 000/010/011/100/110/111 gives ADD/SLT/SLTU/XOR/OR/AND, with imm = sign-extended instr[31:20].
  - f3 001 with f7 = 0000000 gives SSL. f3 101 with f7 = 0000000 gives SSR; with f7 = 0100000 gives SRA.
  - For shifts, imm = zero-extended instr[24:20]. Other f7 values are illegal.
- LUI (0110111): CPY, imm = {instr[31:12], 12'b0}, b_sel_imm = 1, rs1 = rs2 = 0.
- AUIPC (0010111): ADD, a_sel_pc = 1, b_sel_imm = 1, imm as LUI, rs1 = rs2 = 0.
- Illegal instructions:
  - Cases: any other opcode, instr[1:0] != 2'b11, or an illegal field combination.
  - The entry is still delivered with illegal = 1, reg_write = 0, alucode = ADD and all selects = 0.
- reg_write = 1 for legal instructions with rd != 0; reg_write = 0 when rd = 0.
- flush clears both entries: out_valid = 0 and in_ready = 1 on the next cycle.
  - An input transfer in the same cycle as flush is discarded.
  - flush has priority over every other event.

## Timing

- Reset (asynchronous, any time including mid-stall): out_valid = 0, in_ready = 1, both entries empty. All data outputs are 0, so alucode = ADD.
- Latency: an instruction accepted at edge N is presented with out_valid = 1 after edge N.
- Throughput: one instruction per cycle while out_ready = 1.
- in_ready and every out_* signal come directly from registers, with no combinational input-to-output path.
- While out_valid && !out_ready, all out_* signals stay stable.
- Simultaneous drain and accept with the skid empty: the new entry goes directly to the output register.
- Skid full and output draining: in_ready = 0 that cycle; the skid entry moves to the output; in_ready = 1 next cycle.
- At most one stalled instruction is absorbed after out_ready falls. No entry is dropped or duplicated.

## Test plan

- Reset then ADD x3,x1,x2 (0x002081B3) at pc 0x100 -> one cycle later: out_valid = 1, alucode = 0, rs1 = 1, rs2 = 2, rd = 3, b_sel_imm = 0, b_negate = 0, reg_write = 1, out_pc = 0x100.
- SUB (0x402081B3), SRAI x5,x6,7 (0x40735293), ADDI x1,x0,-1 (0xFFF00093) -> ADD with b_negate = 1; SRA with imm = 7 and b_sel_imm = 1; ADD with imm = 0xFFFFFFFF.
- LUI x7,0x12345 (0x123453B7) and AUIPC x8,1 (0x00001417) -> CPY with imm = 0x12345000; ADD with a_sel_pc = 1 and imm = 0x00001000.
- 0x0000000F (FENCE), funct7 = 0000001 OP, ADD with rd = 0 -> illegal = 1 / illegal = 1 / illegal = 0 with reg_write = 0.
- Stream of 8 instructions with out_ready low for 3 cycles mid-stream -> in_ready falls after exactly one extra accept; all 8 delivered in order exactly once; outputs stable while stalled.
- flush asserted with both entries full, plus an input transfer in the same cycle; separately, rst pulsed asynchronously mid-stall -> flush case: out_valid = 0 and in_ready = 1 next cycle, and the flushed and same-cycle inputs never appear; rst case: the same values take effect immediately.
